// File: rtl/ps2_kbd_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_kbd_matrix: PS/2 set-2 keyboard to Spectrum 8x5 matrix, Fn keys  |
// | and modifier state.                  Revision: 1.0                   |
// +----------------------------------------------------------------------+
module ps2_kbd_matrix #(
   parameter int TIMEOUT = 57000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_kbd_clk,
   input  logic        ps2_kbd_data,
   input  logic [15:0] addr,
   output logic [4:0]  key_data,
   output logic [11:1] Fn,
   output logic [2:0]  mod
);

   localparam int c_WDOG_W = $clog2(TIMEOUT + 1);
   localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} state_t;

   logic [2:0]          r_clk_sync;
   logic [1:0]          r_dat_sync;
   logic [9:0]          r_shift;
   logic [3:0]          r_bit_cnt;
   logic [c_WDOG_W-1:0] r_wdog;
   logic                r_code_vld;
   logic [7:0]          r_code;
   state_t              r_state;
   logic [39:0]         r_matrix;
   logic [11:1]         r_fn;
   logic [2:0]          r_mod_l;
   logic [2:0]          r_mod_r;

   logic        w_fall;
   logic [10:0] w_frame;
   logic        w_frame_ok;
   logic        w_is_ext;
   logic        w_make;
   logic        w_brk;
   logic        w_key_hit;
   logic [5:0]  w_key_idx;
   logic [39:0] w_mat_mask;
   logic [11:1] w_fn_mask;
   logic [2:0]  w_mod_l_mask;
   logic [2:0]  w_mod_r_mask;
   logic        w_unused;

   assign w_unused   = ^addr[7:0];
   assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_frame    = {r_dat_sync[1], r_shift};
   assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_kbd_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_kbd_data};
      end
   end

   // A falling edge always wins over a simultaneous watchdog expiry.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_wdog     <= '0;
         r_code_vld <= 1'b0;
         r_code     <= '0;
      end else begin
         r_code_vld <= 1'b0;
         if (w_fall) begin
            r_wdog <= '0;
            if (r_bit_cnt == 4'd10) begin
               r_bit_cnt <= '0;
               if (w_frame_ok) begin
                  r_code_vld <= 1'b1;
                  r_code     <= w_frame[8:1];
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_shift   <= {r_dat_sync[1], r_shift[9:1]};
            end
         end else if (r_wdog == c_WDOG_MAX) begin
            if (r_bit_cnt != 4'd0)
               r_bit_cnt <= '0;
         end else begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign w_is_ext = (r_state == ST_EXT) || (r_state == ST_EXTBRK);
   assign w_make   = r_code_vld &&
                     (((r_state == ST_IDLE) && (r_code != 8'hE0) && (r_code != 8'hF0)) ||
                      ((r_state == ST_EXT) && (r_code != 8'hF0)));
   assign w_brk    = r_code_vld && ((r_state == ST_BRK) || (r_state == ST_EXTBRK));

   // Matrix index is row*5 + column, row 0 = A8, column 0 = D0.
   always_comb begin
      w_key_hit = 1'b1;
      w_key_idx = 6'd0;
      case (r_code)
         8'h12: w_key_idx = 6'd0;  8'h1A: w_key_idx = 6'd1;  8'h22: w_key_idx = 6'd2;  8'h21: w_key_idx = 6'd3;  8'h2A: w_key_idx = 6'd4;
         8'h1C: w_key_idx = 6'd5;  8'h1B: w_key_idx = 6'd6;  8'h23: w_key_idx = 6'd7;  8'h2B: w_key_idx = 6'd8;  8'h34: w_key_idx = 6'd9;
         8'h15: w_key_idx = 6'd10; 8'h1D: w_key_idx = 6'd11; 8'h24: w_key_idx = 6'd12; 8'h2D: w_key_idx = 6'd13; 8'h2C: w_key_idx = 6'd14;
         8'h16: w_key_idx = 6'd15; 8'h1E: w_key_idx = 6'd16; 8'h26: w_key_idx = 6'd17; 8'h25: w_key_idx = 6'd18; 8'h2E: w_key_idx = 6'd19;
         8'h45: w_key_idx = 6'd20; 8'h46: w_key_idx = 6'd21; 8'h3E: w_key_idx = 6'd22; 8'h3D: w_key_idx = 6'd23; 8'h36: w_key_idx = 6'd24;
         8'h4D: w_key_idx = 6'd25; 8'h44: w_key_idx = 6'd26; 8'h43: w_key_idx = 6'd27; 8'h3C: w_key_idx = 6'd28; 8'h35: w_key_idx = 6'd29;
         8'h5A: w_key_idx = 6'd30; 8'h4B: w_key_idx = 6'd31; 8'h42: w_key_idx = 6'd32; 8'h3B: w_key_idx = 6'd33; 8'h33: w_key_idx = 6'd34;
         8'h29: w_key_idx = 6'd35; 8'h59: w_key_idx = 6'd36; 8'h3A: w_key_idx = 6'd37; 8'h31: w_key_idx = 6'd38; 8'h32: w_key_idx = 6'd39;
         default: w_key_hit = 1'b0;
      endcase
   end

   always_comb begin
      w_mat_mask   = '0;
      w_fn_mask    = '0;
      w_mod_l_mask = '0;
      w_mod_r_mask = '0;
      if (w_is_ext) begin
         case (r_code)
            8'h14:   w_mod_r_mask[1] = 1'b1;
            8'h11:   w_mod_r_mask[0] = 1'b1;
            default: ;
         endcase
      end else begin
         if (w_key_hit)
            w_mat_mask = 40'd1 << w_key_idx;
         case (r_code)
            8'h66: begin w_mat_mask[0] = 1'b1; w_mat_mask[20] = 1'b1; end
            8'h12: w_mod_l_mask[2] = 1'b1;
            8'h59: w_mod_r_mask[2] = 1'b1;
            8'h14: w_mod_l_mask[1] = 1'b1;
            8'h11: w_mod_l_mask[0] = 1'b1;
            8'h05: w_fn_mask[1] = 1'b1;  8'h06: w_fn_mask[2] = 1'b1;  8'h04: w_fn_mask[3] = 1'b1;
            8'h0C: w_fn_mask[4] = 1'b1;  8'h03: w_fn_mask[5] = 1'b1;  8'h0B: w_fn_mask[6] = 1'b1;
            8'h83: w_fn_mask[7] = 1'b1;  8'h0A: w_fn_mask[8] = 1'b1;  8'h01: w_fn_mask[9] = 1'b1;
            8'h09: w_fn_mask[10] = 1'b1; 8'h78: w_fn_mask[11] = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_matrix <= '0;
         r_fn     <= '0;
         r_mod_l  <= '0;
         r_mod_r  <= '0;
      end else begin
         if (r_code_vld) begin
            case (r_state)
               ST_IDLE: begin
                  if (r_code == 8'hE0)      r_state <= ST_EXT;
                  else if (r_code == 8'hF0) r_state <= ST_BRK;
               end
               ST_EXT:  r_state <= (r_code == 8'hF0) ? ST_EXTBRK : ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
         if (w_make) begin
            r_matrix <= r_matrix | w_mat_mask;
            r_fn     <= r_fn | w_fn_mask;
            r_mod_l  <= r_mod_l | w_mod_l_mask;
            r_mod_r  <= r_mod_r | w_mod_r_mask;
         end else if (w_brk) begin
            r_matrix <= r_matrix & ~w_mat_mask;
            r_fn     <= r_fn & ~w_fn_mask;
            r_mod_l  <= r_mod_l & ~w_mod_l_mask;
            r_mod_r  <= r_mod_r & ~w_mod_r_mask;
         end
      end
   end

   assign Fn  = r_fn;
   assign mod = r_mod_l | r_mod_r;

   always_comb begin
      key_data = 5'h1F;
      for (int r = 0; r < 8; r++) begin
         if (!addr[8+r])
            key_data = key_data & ~r_matrix[r*5 +: 5];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_kbd_matrix: directed vector table, corner sequences and       |
// | random key events against a keyboard-level model.  Revision: 1.0     |
// +----------------------------------------------------------------------+
module tb_ps2_kbd_matrix;

   localparam int TB_TIMEOUT = 300;
   localparam int NVEC       = 41;
   localparam int NRAND      = 50;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_kbd_clk;
   logic        ps2_kbd_data;
   logic [15:0] addr;
   logic [4:0]  key_data;
   logic [11:1] Fn;
   logic [2:0]  mod;

   int checks   = 0;
   int failures = 0;

   ps2_kbd_matrix #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ps2_kbd_clk  (ps2_kbd_clk),
      .ps2_kbd_data (ps2_kbd_data),
      .addr         (addr),
      .key_data     (key_data),
      .Fn           (Fn),
      .mod          (mod)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      bit          send;
      logic [7:0]  code;
      bit          bad;
      logic [15:0] a;
      logic [4:0]  kd;
      logic [11:1] fn;
      logic [2:0]  md;
   } vec_t;

   vec_t vt [0:NVEC-1];

   logic [7:0] keymap [0:7][0:4];
   logic [7:0] fncode [1:11];
   logic [7:0] extras [0:15];

   bit         mp [0:39];
   logic [11:1] mfn;
   logic [2:0]  mlmod, mrmod;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
      logic p;
      p = (~^b) ^ bad;
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ps2_kbd_data = f[i];
         wait_clk(4);
         ps2_kbd_clk = 1'b0;
         wait_clk(8);
         ps2_kbd_clk = 1'b1;
         wait_clk(4);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad);
      send_bits(mk_frame(b, bad), 0, 10);
      wait_clk(6);
   endtask

   task automatic check_out(input string nm, input logic [15:0] a, input logic [4:0] kd,
                            input logic [11:1] fn, input logic [2:0] md);
      @(negedge clk_sys);
      addr = a;
      #1;
      chk({nm, "_kd"}, {11'd0, key_data}, {11'd0, kd});
      chk({nm, "_fn"}, {5'd0, Fn}, {5'd0, fn});
      chk({nm, "_mod"}, {13'd0, mod}, {13'd0, md});
   endtask

   task automatic check_kd(input string nm, input logic [15:0] a, input logic [4:0] kd);
      @(negedge clk_sys);
      addr = a;
      #1;
      chk(nm, {11'd0, key_data}, {11'd0, kd});
   endtask

   // Keyboard-level model: which Spectrum keys, Fn keys and modifiers are held.
   function automatic logic [4:0] model_kd(input logic [7:0] hi);
      logic [4:0] k;
      k = 5'h1F;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 5; c++)
            if (!hi[r] && mp[r*5+c]) k[c] = 1'b0;
      return k;
   endfunction

   task automatic model_event(input logic [7:0] code, input bit ext, input bit make);
      if (ext) begin
         if (code == 8'h14) mrmod[1] = make;
         if (code == 8'h11) mrmod[0] = make;
      end else begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
               if (keymap[r][c] == code) mp[r*5+c] = make;
         if (code == 8'h66) begin mp[0] = make; mp[20] = make; end
         for (int n = 1; n <= 11; n++)
            if (fncode[n] == code) mfn[n] = make;
         if (code == 8'h12) mlmod[2] = make;
         if (code == 8'h59) mrmod[2] = make;
         if (code == 8'h14) mlmod[1] = make;
         if (code == 8'h11) mlmod[0] = make;
      end
   endtask

   initial begin
      keymap = '{'{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
                 '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
                 '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
                 '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
                 '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
                 '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
                 '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
                 '{8'h29, 8'h59, 8'h3A, 8'h31, 8'h32}};
      fncode = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78};
      extras = '{8'h66, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83,
                 8'h0A, 8'h01, 8'h09, 8'h78, 8'h14, 8'h11, 8'h76, 8'h0D};

      //          send code   bad  addr      kd     fn       mod
      vt[0]  = '{1, 8'h1C, 0, 16'hFDFE, 5'h1E, 11'h000, 3'd0};
      vt[1]  = '{0, 8'h00, 0, 16'hFEFE, 5'h1F, 11'h000, 3'd0};
      vt[2]  = '{1, 8'hF0, 0, 16'hFDFE, 5'h1E, 11'h000, 3'd0};
      vt[3]  = '{1, 8'h1C, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[4]  = '{1, 8'h12, 0, 16'h00FE, 5'h1E, 11'h000, 3'd4};
      vt[5]  = '{1, 8'h4D, 0, 16'h00FE, 5'h1E, 11'h000, 3'd4};
      vt[6]  = '{1, 8'hF0, 0, 16'h00FE, 5'h1E, 11'h000, 3'd4};
      vt[7]  = '{1, 8'h12, 0, 16'hFEFE, 5'h1F, 11'h000, 3'd0};
      vt[8]  = '{0, 8'h00, 0, 16'hDFFE, 5'h1E, 11'h000, 3'd0};
      vt[9]  = '{1, 8'h1C, 1, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[10] = '{1, 8'hF0, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[11] = '{1, 8'h1C, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[12] = '{0, 8'h00, 0, 16'hDFFE, 5'h1E, 11'h000, 3'd0};
      vt[13] = '{1, 8'hF0, 0, 16'hDFFE, 5'h1E, 11'h000, 3'd0};
      vt[14] = '{1, 8'h4D, 0, 16'hDFFE, 5'h1F, 11'h000, 3'd0};
      vt[15] = '{1, 8'hE0, 0, 16'hFFFF, 5'h1F, 11'h000, 3'd0};
      vt[16] = '{1, 8'h14, 0, 16'hFFFF, 5'h1F, 11'h000, 3'd2};
      vt[17] = '{1, 8'h78, 0, 16'hFFFF, 5'h1F, 11'h400, 3'd2};
      vt[18] = '{1, 8'hE0, 0, 16'hFFFF, 5'h1F, 11'h400, 3'd2};
      vt[19] = '{1, 8'hF0, 0, 16'hFFFF, 5'h1F, 11'h400, 3'd2};
      vt[20] = '{1, 8'h14, 0, 16'hFFFF, 5'h1F, 11'h400, 3'd0};
      vt[21] = '{1, 8'hF0, 0, 16'hFFFF, 5'h1F, 11'h400, 3'd0};
      vt[22] = '{1, 8'h78, 0, 16'hFFFF, 5'h1F, 11'h000, 3'd0};
      vt[23] = '{1, 8'h05, 0, 16'hFFFF, 5'h1F, 11'h001, 3'd0};
      vt[24] = '{1, 8'h83, 0, 16'hFFFF, 5'h1F, 11'h041, 3'd0};
      vt[25] = '{1, 8'hF0, 0, 16'hFFFF, 5'h1F, 11'h041, 3'd0};
      vt[26] = '{1, 8'h05, 0, 16'hFFFF, 5'h1F, 11'h040, 3'd0};
      vt[27] = '{1, 8'hF0, 0, 16'hFFFF, 5'h1F, 11'h040, 3'd0};
      vt[28] = '{1, 8'h83, 0, 16'hFFFF, 5'h1F, 11'h000, 3'd0};
      vt[29] = '{1, 8'h66, 0, 16'hFEFE, 5'h1E, 11'h000, 3'd0};
      vt[30] = '{0, 8'h00, 0, 16'hEFFE, 5'h1E, 11'h000, 3'd0};
      vt[31] = '{0, 8'h00, 0, 16'hFFFF, 5'h1F, 11'h000, 3'd0};
      vt[32] = '{1, 8'hF0, 0, 16'hFEFE, 5'h1E, 11'h000, 3'd0};
      vt[33] = '{1, 8'h66, 0, 16'hFEFE, 5'h1F, 11'h000, 3'd0};
      vt[34] = '{1, 8'hE0, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[35] = '{1, 8'h1C, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[36] = '{1, 8'hE0, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[37] = '{1, 8'hF0, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[38] = '{1, 8'h1C, 0, 16'hFDFE, 5'h1F, 11'h000, 3'd0};
      vt[39] = '{1, 8'hE0, 0, 16'hFEFE, 5'h1F, 11'h000, 3'd0};
      vt[40] = '{1, 8'h12, 0, 16'hFEFE, 5'h1F, 11'h000, 3'd0};

      reset        = 1'b1;
      ps2_kbd_clk  = 1'b1;
      ps2_kbd_data = 1'b1;
      addr         = 16'hFFFF;
      wait_clk(5);
      reset = 1'b0;
      check_out("reset_00", 16'h00FE, 5'h1F, 11'h000, 3'd0);
      check_kd("reset_ff", 16'hFFFF, 5'h1F);

      for (int i = 0; i < NVEC; i++) begin
         if (vt[i].send) send_byte(vt[i].code, vt[i].bad);
         check_out($sformatf("vec%0d", i), vt[i].a, vt[i].kd, vt[i].fn, vt[i].md);
      end

      // Stalled partial frame must be flushed by the watchdog.
      send_bits(mk_frame(8'h1C, 1'b0), 0, 3);
      wait_clk(TB_TIMEOUT + 10);
      send_byte(8'h29, 1'b0);
      check_kd("timeout_space", 16'h7FFE, 5'h1E);
      check_kd("timeout_no_a", 16'hFDFE, 5'h1F);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      check_kd("timeout_release", 16'h7FFE, 5'h1F);

      // A pause shorter than the watchdog leaves the frame intact.
      send_bits(mk_frame(8'h29, 1'b0), 0, 3);
      wait_clk(TB_TIMEOUT - 60);
      send_bits(mk_frame(8'h29, 1'b0), 4, 10);
      wait_clk(6);
      check_kd("short_pause", 16'h7FFE, 5'h1E);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);

      // Reset in the middle of a frame.
      send_byte(8'h66, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h78, 1'b0);
      check_out("pre_reset", 16'hFEFE, 5'h1E, 11'h400, 3'd4);
      send_bits(mk_frame(8'h1C, 1'b0), 0, 5);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      check_out("mid_reset", 16'h00FE, 5'h1F, 11'h000, 3'd0);
      wait_clk(20);
      send_byte(8'h29, 1'b0);
      check_out("post_reset", 16'h7FFE, 5'h1E, 11'h000, 3'd0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      check_kd("post_reset_rel", 16'h7FFE, 5'h1F);

      for (int i = 0; i < 40; i++) mp[i] = 1'b0;
      mfn = '0; mlmod = '0; mrmod = '0;

      for (int e = 0; e < NRAND; e++) begin
         int          idx;
         logic [7:0]  code, hi;
         bit          ext, make;
         idx  = $urandom_range(0, 55);
         code = (idx < 40) ? keymap[idx/5][idx%5] : extras[idx-40];
         ext  = ($urandom_range(0, 4) == 0);
         make = ($urandom_range(0, 1) == 1);
         if (ext) send_byte(8'hE0, 1'b0);
         if (!make) send_byte(8'hF0, 1'b0);
         send_byte(code, 1'b0);
         model_event(code, ext, make);
         hi = 8'($urandom_range(0, 255));
         check_out($sformatf("rand%0d_%h", e, code), {hi, 8'hFE}, model_kd(hi), mfn, mlmod | mrmod);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
